// File: rtl/rgb_pkg.sv
// Shared constants and channel helpers for the RGB PWM driver.
package rgb_pkg;

  localparam int RGB_W     = 24;
  localparam int CH_W      = 8;
  localparam int R_OFF     = 16;
  localparam int G_OFF     = 8;
  localparam int B_OFF     = 0;
  localparam int PWM_STEPS = 256;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } ch_e;

  typedef logic [CH_W-1:0] duty_t;

  function automatic duty_t ch_duty(
    input logic [RGB_W-1:0] rgb,
    input ch_e              ch
  );
    case (ch)
      CH_R:    ch_duty = rgb[R_OFF +: CH_W];
      CH_G:    ch_duty = rgb[G_OFF +: CH_W];
      default: ch_duty = rgb[B_OFF +: CH_W];
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM channel: registered compare of step counter against duty.
// RGB_PWM_ACTIVE_LOW_EN selects inverted (common-anode) LED levels.
module pwm_channel
  import rgb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  enable,
  input  duty_t cnt,
  input  duty_t duty,
  output logic  led
);

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  logic led_q, led_d;

  always_comb begin
    led_d = LED_OFF;
    if (enable) begin
      led_d = (cnt < duty) ^ LED_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= LED_OFF;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driven by a 24-bit RGB code, glitch-free reload.
// RGB_PWM_ACTIVE_LOW_EN selects inverted (common-anode) LED levels.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int PRE_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             rgb_load,
  output logic             led_r,
  output logic             led_g,
  output logic             led_b,
  output logic             period_start
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam duty_t            CNT_MAX = duty_t'(PWM_STEPS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  duty_t            cnt_q, cnt_d;
  logic [RGB_W-1:0] shadow_q, shadow_d;
  logic [RGB_W-1:0] active_q, active_d;
  logic             en_q, en_d;
  logic             ps_q, ps_d;
  logic             rise, run, tick, wrap;

  // The rising-enable edge only loads duty; counting starts after it
  // so the first period is a full clean one starting at cnt 0.
  always_comb begin
    en_d     = enable;
    rise     = enable && !en_q;
    run      = enable && en_q;
    tick     = run && (pre_q == PRE_MAX);
    wrap     = tick && (cnt_q == CNT_MAX);
    pre_d    = '0;
    cnt_d    = '0;
    if (run) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    end
    shadow_d = rgb_load ? rgb_in : shadow_q;
    active_d = active_q;
    if (wrap || rise) begin
      active_d = rgb_load ? rgb_in : shadow_q;
    end
    ps_d     = wrap || rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      en_q     <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      en_q     <= en_d;
      ps_q     <= ps_d;
    end
  end

  assign period_start = ps_q;

  pwm_channel u_ch_r (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (ch_duty(active_q, CH_R)),
    .led    (led_r)
  );

  pwm_channel u_ch_g (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (ch_duty(active_q, CH_G)),
    .led    (led_g)
  );

  pwm_channel u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cnt    (cnt_q),
    .duty   (ch_duty(active_q, CH_B)),
    .led    (led_b)
  );

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Drives three LED channels with PWM from a 24-bit RGB code.
- Sits directly downstream of the colour-to-RGB memory stage and consumes its 24-bit read data.
- Input layout: R = rgb_in[23:16], G = rgb_in[15:8], B = rgb_in[7:0].
- Each channel's 8-bit value sets its duty cycle over a 256-step PWM period. A new colour is applied only at a period boundary, so there are no glitches.

Parameters:
- PRESCALE, 4: clock cycles per PWM step; legal range ≥1. Period = 256*PRESCALE cycles.
- PRE_W, 8: prescaler counter width; must satisfy 2**PRE_W ≥ PRESCALE.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  asynchronous active-high reset
- enable  in  1  run PWM; low = outputs forced inactive, counters held at 0
- rgb_in  in  24  colour code from upstream memory read data
- rgb_load  in  1  one-cycle strobe: capture rgb_in into shadow register (asserted the cycle after the memory read enable)
- led_r  out  1  red PWM output
- led_g  out  1  green PWM output
- led_b  out  1  blue PWM output
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period

Behaviour:
- Reset (async, rst=1): prescaler=0, step counter cnt=0, shadow=0, active duty registers=0, led_r/g/b=0, period_start=0. Outputs stay at these values while rst is high.
- Shadow register:
  - Loads rgb_in on any clk edge with rgb_load=1, regardless of enable.
  - The last load wins. Multiple loads within one period are legal; only the final one is applied.
- Prescaler and step counter:
  - When enable=1, the prescaler counts 0..PRESCALE-1 and wraps.
  - tick = enable && (prescaler==PRESCALE-1).
  - cnt (8 bits) increments on tick and wraps 255->0.
  - PRESCALE=1 means a tick every cycle.
- Period boundary (wrap = tick && cnt==255):
  - On a wrap edge, the active duty registers load from the shadow.
  - If rgb_load=1 on the same edge, rgb_in is used directly (bypass), so the new colour applies to the period that starts immediately.
- Compare: comb_x = (cnt < active_x), using 8-bit unsigned compare.
  - duty 0 = never high.
  - duty 255 = high 255 of 256 steps.
  - Full-on is not reachable; this is by design.
- Outputs: led_x <= enable ? comb_x : 0. Outputs are registered, one clk of latency after cnt/active change.
- period_start: registered.
  - Pulses for one cycle on the first clk after a wrap edge.
  - Also pulses on the first cycle after enable rises.
- Enable falling:
  - Next edge: prescaler=0, cnt=0, led_x=0.
  - Active duty registers are not touched; shadow keeps loading.
- Enable rising (the edge where enable is first sampled high after being low, including the first edge after reset with enable=1):
  - Active registers load from shadow, with rgb_load bypass as above.
  - cnt starts at 0, so a full clean period begins.
- Reset asserted mid-period: all state clears immediately; after release the block behaves as from power-up.
- Width rules: no arithmetic beyond the counters; all compares are unsigned 8-bit.

Optional Feature:
- Macro RGB_PWM_ACTIVE_LOW_EN.
- Defined: led_r/g/b are inverted for common-anode LEDs. Reset, disabled and duty-0 levels all become 1.
- Undefined: active-high as described above.
- period_start is unaffected in both cases.

Decomposition:
- Shared package rgb_pkg:
  - constants RGB_W=24 and CH_W=8
  - R/G/B bit-slice offsets (16, 8, 0)
  - PWM_STEPS=256
  - channel index enum {CH_R, CH_G, CH_B}
- One natural sub-module, pwm_channel: takes cnt, active duty and enable, and produces one registered LED output. It is instantiated 3 times. Prescaler, cnt, shadow and boundary logic stay in the top block.

Test Plan:
1. Reset mid-run: assert rst while led_r=1 → all outputs 0 in the same cycle (asynchronous); after release with enable=1 and no load, outputs stay 0.
2. PRESCALE=1, load rgb_in=24'hFF8000, then enable → per 256-cycle period:
   - led_r high 255 cycles
   - led_g high exactly 128 cycles (first 128 steps)
   - led_b never high
   - period_start pulses every 256 cycles
3. Mid-period reload: running with 24'h404040, rgb_load 24'h00C000 at step 100 → current period finishes at duty 64 on all channels; next period gives G=192, R=B=0.
4. Load coincident with wrap (rgb_load on the cnt==255 tick edge, value 24'h0000FF) → the very next period already shows B=255.
5. PRESCALE=4, duty 24'h010000 → led_r high for exactly 4 cycles per 1024-cycle period.
6. Enable low for 10 cycles mid-period → outputs 0 throughout, then period_start one cycle after re-enable and cnt restarts at 0. Rerun with RGB_PWM_ACTIVE_LOW_EN defined → same timing, LED levels inverted.
